csr_bank: RTL
=============

# csr_bank

Parametrised control/status register bank for the pipelined CPU, the multi-entry successor to the single 4-bit CSR register. Holds NREGS registers of WIDTH bits, each with its own reset value and software-writable bit mask. Supports write/set/clear operations staged at EX and committed at WB, with flush cancellation. A hardware sticky-set port lets events such as interrupt pending flags set bits without being lost to concurrent software writes.

## Interface
- WIDTH, 4: bits per register.
- NREGS, 4: number of registers, 1..16.
- AW, 2: address width; NREGS ≤ 2**AW.
- RESET_VALS, {NREGS{4'hF}}: flattened per-register reset values; register i is bits [i*WIDTH +: WIDTH].
- WMASKS, {NREGS{4'hF}}: flattened per-register software-writable masks; 0 bits are read-only to software.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- csr_en  in  1  software request valid (EX stage).
- csr_op  in  2  00 read, 01 write, 10 set, 11 clear.
- csr_addr  in  AW  target register.
- csr_wdata  in  WIDTH  operand.
- csr_rdata  out  WIDTH  combinational read value for the current request.
- csr_busy  out  1  request not accepted this cycle.
- csr_illegal  out  1  combinational: csr_en with csr_addr ≥ NREGS.
- commit  in  1  apply the pending write (WB stage).
- flush  in  1  discard the pending write.
- hw_set  in  NREGS*WIDTH  per-bit sticky set, sampled every cycle.
- regs_flat  out  NREGS*WIDTH  all current register values, for direct decode by the core.

## Operation
- State: the register array reg[i], plus one pending slot: pend_valid, pend_op, pend_addr, pend_data.
- A request is accepted when csr_en && !csr_illegal && !csr_busy.
- csr_busy = csr_en && pend_valid && !(commit && !flush).
- On acceptance with csr_op ≠ 00, the slot captures the request and pend_valid is set next cycle.
- A read (op 00) never occupies the slot.
- Illegal requests are never accepted; csr_rdata is 0 for them.
- Commit (pend_valid && commit && !flush) computes the new value from the register value current at commit time, using M = WMASKS[a]:
  - Write: (pend_data & M) | (reg & ~M).
  - Set: reg | (pend_data & M).
  - Clear: reg & ~(pend_data & M).
- hw_set is ORed in after the software result in the same cycle, so hardware set always beats software clear on the same bit.
- With no commit, reg[i] <= reg[i] | hw_set[i] every cycle.
- Flush clears pend_valid. If flush and commit arrive together, flush wins and reg is unchanged except for hw_set.
- Commit or flush with !pend_valid has no effect.
- csr_rdata forwarding: if pend_valid && pend_addr == csr_addr, return the pending op applied to the current reg; otherwise return reg[csr_addr]. hw_set in the same cycle is not forwarded.
- Commit plus a new accepted request in the same cycle: the slot is reloaded with the new request. Its csr_rdata forwards the committing result (excluding hw_set).
- Reset: every reg[i] = RESET_VALS[i], pend_valid = 0, csr_busy = 0, regs_flat = RESET_VALS.

## Timing
- Read latency 0: csr_rdata is combinational.
- Accept at cycle N. Commit is possible from cycle N+1; the register updates at the end of the commit cycle, so regs_flat shows the new value in the following cycle.
- Throughput: one write per cycle when each commit overlaps the next request.
- Reset asserted mid-operation drops the pending write immediately and asynchronously.
- hw_set has a 1-cycle effect: a bit set at cycle N is visible on regs_flat at N+1.

## Structure
- Shared package csr_pkg: op encodings (CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR), the op-apply function apply_op(op, cur, data, mask), and default reset/mask constants.
- One sub-module, csr_reg_cell: a single WIDTH-bit register with async reset value, commit-enable, computed next value and hw_set OR. It is instantiated NREGS times via generate.
- The pending slot, forwarding and busy logic live in the top level.

## Test plan
- Reset: assert rst mid-pending (reg1 write 4'h3 accepted). Require regs_flat = 16'hFFFF, pend_valid = 0, and reg1 still 4'hF after release.
- Clear then commit: op 11 on reg2 with data 4'h5, commit next cycle. Require reg2 = 4'hA. A write of 4'h0 with WMASKS[2] = 4'h3 gives 4'hC.
- Back-to-back with forwarding: write reg0 = 4'h2 accepted, then the next cycle set reg0 with 4'h1 plus commit. Require csr_rdata = 4'h2, busy = 0, and final reg0 = 4'h3.
- Busy and flush: a pending write to reg3 followed by a new request without commit. Require busy = 1. Then flush+commit together: require reg3 unchanged and the next request accepted.
- hw_set priority: committing a clear of reg1 with 4'hF while hw_set for reg1 = 4'h8 in the same cycle. Require reg1 = 4'h8.
- Illegal address: with NREGS = 3, a request to addr 3. Require csr_illegal = 1, csr_rdata = 0, no pend_valid, and no state change.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR bank: op encodings, op-apply helper and defaults.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  localparam int         DEF_WIDTH     = 4;
  localparam int         DEF_NREGS     = 4;
  localparam int         DEF_AW        = 2;
  localparam logic [3:0] DEF_RESET_VAL = 4'hF;
  localparam logic [3:0] DEF_WMASK     = 4'hF;

  // Operands are zero-extended to 32 bits by the caller; bits outside the mask are preserved.
  function automatic logic [31:0] apply_op(csr_op_e op, logic [31:0] cur,
                                           logic [31:0] data, logic [31:0] mask);
    logic [31:0] dm;
    dm = data & mask;
    case (op)
      CSR_WRITE: return dm | (cur & ~mask);
      CSR_SET:   return cur | dm;
      CSR_CLEAR: return cur & ~dm;
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/csr_bank_if.sv
// Software-side request/commit bus of the CSR bank.
interface csr_bank_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 2
);
  logic             csr_en;
  logic [1:0]       csr_op;
  logic [AW-1:0]    csr_addr;
  logic [WIDTH-1:0] csr_wdata;
  logic [WIDTH-1:0] csr_rdata;
  logic             csr_busy;
  logic             csr_illegal;
  logic             commit;
  logic             flush;

  modport master (
    output csr_en, csr_op, csr_addr, csr_wdata, commit, flush,
    input  csr_rdata, csr_busy, csr_illegal
  );

  modport slave (
    input  csr_en, csr_op, csr_addr, csr_wdata, commit, flush,
    output csr_rdata, csr_busy, csr_illegal
  );
endinterface

// File: rtl/csr_reg_cell.sv
// One CSR register: async reset value, commit-loaded next value, sticky hardware set.
module csr_reg_cell #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_en,
  input  logic [WIDTH-1:0] next_val,
  input  logic [WIDTH-1:0] hw_set,
  output logic [WIDTH-1:0] q
);

  // hw_set is ORed after the software result so hardware always wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            q <= RESET_VAL;
    else if (commit_en) q <= next_val | hw_set;
    else                q <= q | hw_set;
  end

endmodule

// File: rtl/csr_bank.sv
// Parametrised CSR bank with an EX-staged pending slot committed at WB.
module csr_bank
  import csr_pkg::*;
#(
  parameter int                     WIDTH      = DEF_WIDTH,
  parameter int                     NREGS      = DEF_NREGS,
  parameter int                     AW         = DEF_AW,
  parameter logic [NREGS*WIDTH-1:0] RESET_VALS = {NREGS{DEF_RESET_VAL}},
  parameter logic [NREGS*WIDTH-1:0] WMASKS     = {NREGS{DEF_WMASK}}
) (
  input  logic                   clk,
  input  logic                   rst,
  csr_bank_if.slave              bus,
  input  logic [NREGS*WIDTH-1:0] hw_set,
  output logic [NREGS*WIDTH-1:0] regs_flat
);

  logic             pend_valid;
  csr_op_e          pend_op;
  logic [AW-1:0]    pend_addr;
  logic [WIDTH-1:0] pend_data;

  logic             illegal;
  logic             busy;
  logic             accept;
  logic             load;
  logic             do_commit;
  logic [WIDTH-1:0] cur_rd;
  logic [WIDTH-1:0] cur_pend;
  logic [WIDTH-1:0] mask_pend;
  logic [WIDTH-1:0] commit_val;

  assign illegal   = bus.csr_en && (int'(bus.csr_addr) >= NREGS);
  assign do_commit = pend_valid && bus.commit && !bus.flush;
  assign busy      = bus.csr_en && pend_valid && !(bus.commit && !bus.flush);
  assign accept    = bus.csr_en && !illegal && !busy;
  assign load      = accept && (csr_op_e'(bus.csr_op) != CSR_READ);

  // Loop-based selects keep addressing safe when NREGS < 2**AW.
  always_comb begin
    cur_rd    = '0;
    cur_pend  = '0;
    mask_pend = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(pend_addr) == i) begin
        cur_pend  = regs_flat[i*WIDTH +: WIDTH];
        mask_pend = WMASKS[i*WIDTH +: WIDTH];
      end
      if (int'(bus.csr_addr) == i) cur_rd = regs_flat[i*WIDTH +: WIDTH];
    end
  end

  assign commit_val = WIDTH'(apply_op(pend_op, 32'(cur_pend), 32'(pend_data), 32'(mask_pend)));

  // Forward the pending result (without same-cycle hw_set) to a read of the same register.
  always_comb begin
    bus.csr_rdata = cur_rd;
    if (illegal)
      bus.csr_rdata = '0;
    else if (pend_valid && (pend_addr == bus.csr_addr))
      bus.csr_rdata = commit_val;
  end

  assign bus.csr_busy    = busy;
  assign bus.csr_illegal = illegal;

  // Pending slot: control bit under reset, payload only captured on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          pend_valid <= 1'b0;
    else if (load)                    pend_valid <= 1'b1;
    else if (do_commit || bus.flush)  pend_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pend_op   <= csr_op_e'(bus.csr_op);
      pend_addr <= bus.csr_addr;
      pend_data <= bus.csr_wdata;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    csr_reg_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VALS[g*WIDTH +: WIDTH])
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .commit_en (do_commit && (int'(pend_addr) == g)),
      .next_val  (commit_val),
      .hw_set    (hw_set[g*WIDTH +: WIDTH]),
      .q         (regs_flat[g*WIDTH +: WIDTH])
    );
  end

endmodule
